fxp_div_q44: RTL

FXP_DIV_Q44 -- requirements
Module: fxp_div_q44

---
 rtl/fxp_div_q44.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fxp_div_q44.sv
// Signed Q4.4 divider: dout = x1 / x2, rounded half away from zero and
// saturated to the Q4.4 range. A restoring divider produces one quotient
// bit per cycle, so every operation (including divide-by-zero) takes a fixed
// 13 cycles from the accepting edge to the done edge.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only while idle
//   x1     dividend, signed Q4.4
//   x2     divisor, signed Q4.4
//   busy   high while an operation is in flight
//   done   one-cycle pulse when dout/dz are updated
//   dout   quotient, signed Q4.4, rounded and saturated
//   dz     divide-by-zero flag for the last completed operation
module fxp_div_q44 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] x1,
  input  logic [7:0] x2,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       dz
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t      state;
  logic [11:0] q;       // dividend shifts out the top, quotient bits shift in
  logic [7:0]  r;       // partial remainder, always < divisor magnitude
  logic [8:0]  d;       // divisor magnitude (0x80 -> 128 needs 9 bits)
  logic [3:0]  cnt;
  logic        neg;
  logic        zdiv;
  logic        x1neg;
  logic        x1zero;

  logic [8:0]  a1;
  logic [8:0]  a2;
  logic [8:0]  rsh;
  logic        ge;
  logic [7:0]  rnext;
  logic [12:0] mag;
  logic [7:0]  res;

  // Magnitudes in 9 bits so that -128 becomes +128 without overflow.
  always_comb begin
    a1 = x1[7] ? (9'd256 - {1'b0, x1}) : {1'b0, x1};
    a2 = x2[7] ? (9'd256 - {1'b0, x2}) : {1'b0, x2};
  end

  // One restoring step.
  always_comb begin
    rsh   = {r, q[11]};
    ge    = (rsh >= d);
    rnext = ge ? 8'(rsh - d) : rsh[7:0];
  end

  // Round on magnitude, then apply sign with saturation. The divide-by-zero
  // case ignores the (meaningless) quotient register entirely.
  always_comb begin
    mag = {1'b0, q} + 13'(({r, 1'b0} >= d));
    res = '0;
    if (zdiv) begin
      if (x1zero)     res = 8'h00;
      else if (x1neg) res = 8'h80;
      else            res = 8'h7F;
    end else if (mag == '0) begin
      res = 8'h00;
    end else if (!neg) begin
      res = (mag > 13'd127) ? 8'h7F : mag[7:0];
    end else begin
      res = (mag > 13'd128) ? 8'h80 : 8'(8'd0 - mag[7:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      dout   <= '0;
      dz     <= 1'b0;
      q      <= '0;
      r      <= '0;
      d      <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      zdiv   <= 1'b0;
      x1neg  <= 1'b0;
      x1zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            q      <= {a1[7:0], 4'b0000};
            // a1 == 128 does not fit in 8 bits; its <<4 is 0x800
            if (a1[8]) q <= 12'h800;
            r      <= '0;
            d      <= a2;
            cnt    <= '0;
            neg    <= x1[7] ^ x2[7];
            zdiv   <= (x2 == 8'h00);
            x1neg  <= x1[7];
            x1zero <= (x1 == 8'h00);
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          q   <= {q[10:0], ge};
          r   <= rnext;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd11) state <= FIN;
        end
        FIN: begin
          dout  <= res;
          dz    <= zdiv;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
